multi_ch_delay_line: RTL and testbench

//  Programmable, sample-count delay line for NUM_CH parallel channels that share one valid strobe.

---
 rtl/multi_ch_delay_line.sv | 115 +++++++++++
 tb/tb_multi_ch_delay_line.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_delay_line.sv
// Multi-channel ring-buffer delay line with runtime delay change and flush.
// Optional DELAY_LINE_FILL_ZERO_EN: emit zero-valued samples while priming.
module multi_ch_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int RST_WAIT   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        delay_ctl,
  input  logic                         flush,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         data_in_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         data_out_valid,
  output logic [ADDR_WIDTH-1:0]        delay_applied,
  output logic                         filled
);

  localparam int W     = NUM_CH * DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] wptr_q;
  logic [ADDR_WIDTH-1:0] fill_cnt_q;
  logic [7:0]            wait_cnt_q;
  logic [ADDR_WIDTH-1:0] dly_q;
  logic [W-1:0]          dout_q;
  logic                  dvld_q;
  logic [W-1:0]          mem_q [DEPTH];

  logic                  active;
  logic                  restart_d;
  logic                  wr_en_d;
  logic                  fill_last_d;
  logic [ADDR_WIDTH-1:0] raddr_d;
  logic [W-1:0]          rd_data_d;

  always_comb begin
    active      = (state_q == FILL) || (state_q == RUN);
    restart_d   = active && (flush || (delay_ctl != dly_q));
    wr_en_d     = active && data_in_valid && !restart_d;
    fill_last_d = (ADDR_WIDTH'(fill_cnt_q + 1'b1) == dly_q);
    raddr_d     = wptr_q - dly_q;
    // Zero delay reads the sample arriving this cycle.
    rd_data_d   = (dly_q == '0) ? data_in : mem_q[raddr_d];
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en_d) begin
      mem_q[wptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      fill_cnt_q <= '0;
      wait_cnt_q <= '0;
      dly_q      <= '0;
      dout_q     <= '0;
      dvld_q     <= 1'b0;
    end else begin
      dvld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (wait_cnt_q == 8'(RST_WAIT - 1)) begin
            dly_q   <= delay_ctl;
            state_q <= (delay_ctl == '0) ? RUN : FILL;
          end
        end
        FILL, RUN: begin
          if (restart_d) begin
            // Drop the sample in this cycle and refill from slot 0.
            dly_q      <= delay_ctl;
            wptr_q     <= '0;
            fill_cnt_q <= '0;
            state_q    <= (delay_ctl == '0) ? RUN : FILL;
          end else if (data_in_valid) begin
            wptr_q <= wptr_q + 1'b1;
            if (state_q == FILL) begin
              fill_cnt_q <= fill_cnt_q + 1'b1;
              if (fill_last_d) begin
                state_q <= RUN;
              end
`ifdef DELAY_LINE_FILL_ZERO_EN
              dout_q <= '0;
              dvld_q <= 1'b1;
`endif
            end else begin
              dout_q <= rd_data_d;
              dvld_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dvld_q;
  assign delay_applied  = dly_q;
  assign filled         = (state_q == RUN);

endmodule

// File: tb/tb_multi_ch_delay_line.sv
// Directed scoreboard bench for multi_ch_delay_line.
// Optional DELAY_LINE_FILL_ZERO_EN changes the fill-phase expectation.
module tb_multi_ch_delay_line;

  localparam int DW = 8;
  localparam int NC = 2;
  localparam int AW = 6;
  localparam int RW = 8;
  localparam int W  = NC * DW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] delay_ctl;
  logic          flush;
  logic [W-1:0]  data_in;
  logic          data_in_valid;
  logic [W-1:0]  data_out;
  logic          data_out_valid;
  logic [AW-1:0] delay_applied;
  logic          filled;

  multi_ch_delay_line #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NC),
    .ADDR_WIDTH(AW),
    .RST_WAIT  (RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .delay_ctl     (delay_ctl),
    .flush         (flush),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .delay_applied (delay_applied),
    .filled        (filled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [W-1:0] q [$];
  logic [W-1:0] hist [$];
  logic [W-1:0] last_exp;
  int           delay_m;
  int           x;

  function automatic logic [W-1:0] mk(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {~b, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_in(input logic [W-1:0] d);
    int n;
    hist.push_back(d);
    n = hist.size();
    if (n > delay_m) begin
      q.push_back(hist[n-1-delay_m]);
    end else begin
`ifdef DELAY_LINE_FILL_ZERO_EN
      q.push_back('0);
`endif
    end
  endtask

  // acc=0: the DUT must ignore or drop this sample.
  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic acc);
    logic [W-1:0] e;
    data_in_valid = v;
    data_in       = d;
    if (v && acc) model_in(d);
    @(posedge clk);
    #1;
    check("out_valid", 32'(data_out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      e        = q.pop_front();
      last_exp = e;
      check("out_data", 32'(data_out), 32'(e));
    end else begin
      check("out_hold", 32'(data_out), 32'(last_exp));
    end
    data_in_valid = 1'b0;
  endtask

  task automatic do_reset(input logic [AW-1:0] d);
    delay_ctl     = d;
    flush         = 1'b0;
    data_in_valid = 1'b0;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_out_valid), 32'h0);
    check("rst_filled", 32'(filled), 32'h0);
    check("rst_delay", 32'(delay_applied), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    hist.delete();
    last_exp = '0;
    delay_m  = int'(d);
    for (int i = 0; i < RW - 1; i++) step(1'b1, 16'hdead, 1'b0);
    check("idle_delay", 32'(delay_applied), 32'h0);
    check("idle_filled", 32'(filled), 32'h0);
    step(1'b1, 16'hbeef, 1'b0);
    check("entry_delay", 32'(delay_applied), 32'(d));
    check("entry_filled", 32'(filled), 32'(d == '0));
  endtask

  task automatic restart(input logic [AW-1:0] d, input logic fl);
    delay_ctl = d;
    flush     = fl;
    step(1'b1, 16'h5a5a, 1'b0);
    flush   = 1'b0;
    hist.delete();
    delay_m = int'(d);
    check("restart_delay", 32'(delay_applied), 32'(d));
    check("restart_filled", 32'(filled), 32'(d == '0));
  endtask

  initial begin
    rst           = 1'b1;
    delay_ctl     = '0;
    flush         = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    last_exp      = '0;
    delay_m       = 0;

    // Delay 5, continuous ramp.
    do_reset(6'd5);
    for (int i = 1; i <= 20; i++) step(1'b1, mk(i), 1'b1);
    check("t1_filled", 32'(filled), 32'h1);

    // Switch delay 5 -> 10 while running.
    restart(6'd10, 1'b0);
    for (int i = 1; i <= 10; i++) step(1'b1, mk(100 + i), 1'b1);
    check("t3_filled", 32'(filled), 32'h1);
    for (int i = 11; i <= 25; i++) step(1'b1, mk(100 + i), 1'b1);

    // Delay 0 bypass, valid every third cycle.
    do_reset(6'd0);
    for (int i = 0; i < 36; i++) step(i % 3 == 0, mk(40 + i), 1'b1);

    // Maximum delay across several ring wraps.
    restart(6'd63, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, mk(i), 1'b1);
    check("t4_filled", 32'(filled), 32'h1);

    // Flush mid-run, then refill with a gap pattern.
    restart(6'd63, 1'b1);
    x = 7;
    for (int i = 0; i < 80; i++) begin
      step(i % 4 != 3, mk(x), 1'b1);
      if (i % 4 != 3) x++;
    end

    // Flush together with a delay change takes the new delay.
    restart(6'd3, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, mk(200 + i), 1'b1);

    // Reset mid-run, then refill at delay 63.
    do_reset(6'd63);
    for (int i = 0; i < 70; i++) step(1'b1, mk(3 * i), 1'b1);

`ifdef DELAY_LINE_FILL_ZERO_EN
    // Zero-filled priming at delay 4.
    do_reset(6'd4);
    for (int i = 1; i <= 10; i++) step(1'b1, mk(i), 1'b1);
`endif

    check("queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
